// File: rtl/pipeline_ctrl.sv
// Backward-direction pipeline control. Produces the stall, flush and next-PC
// select signals from load-use, branch, divide and exception status.
module pipeline_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic [4:0]       EXE_Dst,
  input  logic             EXE_ReadMem,
  input  logic             EXE_BranchTaken,
  input  logic             EXE_DivStart,
  input  logic             MEM_ExceptValid,
  output logic             IF_PCWr,
  output logic             IF_IDWr,
  output logic             IFID_Flush,
  output logic             IDEXE_Wr,
  output logic             IDEXE_Flush,
  output logic             EXEMEM_Flush,
  output logic [1:0]       NPCSel,
  output logic             DivBusy,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {RUN, DIV_BUSY, EXC_HOLD} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [7:0]       div_cnt_reg, div_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             load_use;

  assign load_use = EXE_ReadMem && (EXE_Dst != 5'd0) &&
                    ((EXE_Dst == ID_rs) || (EXE_Dst == ID_rt));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= RUN;
      div_cnt_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    div_cnt_next = div_cnt_reg;
    case (state_reg)
      RUN: begin
        if (MEM_ExceptValid) begin
          state_next = EXC_HOLD;
        end else if (EXE_DivStart) begin
          state_next   = DIV_BUSY;
          div_cnt_next = DIV_LOAD;
        end
      end
      DIV_BUSY: begin
        if (MEM_ExceptValid) begin
          state_next = EXC_HOLD;
        end else if (div_cnt_reg != 8'd0) begin
          div_cnt_next = div_cnt_reg - 8'd1;
        end else begin
          state_next = RUN;
        end
      end
      EXC_HOLD: state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  always_comb begin
    IF_PCWr      = 1'b1;
    IF_IDWr      = 1'b1;
    IFID_Flush   = 1'b0;
    IDEXE_Wr     = 1'b1;
    IDEXE_Flush  = 1'b0;
    EXEMEM_Flush = 1'b0;
    NPCSel       = 2'b00;
    DivBusy      = 1'b0;
    if (!rst) begin
      IF_PCWr  = 1'b0;
      IF_IDWr  = 1'b0;
      IDEXE_Wr = 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (MEM_ExceptValid) begin
            NPCSel       = 2'b10;
            IFID_Flush   = 1'b1;
            IDEXE_Flush  = 1'b1;
            EXEMEM_Flush = 1'b1;
          end else if (EXE_DivStart) begin
            IF_PCWr      = 1'b0;
            IF_IDWr      = 1'b0;
            IDEXE_Wr     = 1'b0;
            EXEMEM_Flush = 1'b1;
          end else if (EXE_BranchTaken) begin
            // Delay slot in ID advances; only the wrong-path fetch is squashed.
            NPCSel     = 2'b01;
            IFID_Flush = 1'b1;
          end else if (load_use) begin
            IF_PCWr     = 1'b0;
            IF_IDWr     = 1'b0;
            IDEXE_Flush = 1'b1;
          end
        end
        DIV_BUSY: begin
          DivBusy = 1'b1;
          if (MEM_ExceptValid) begin
            NPCSel       = 2'b10;
            IFID_Flush   = 1'b1;
            IDEXE_Flush  = 1'b1;
            EXEMEM_Flush = 1'b1;
          end else if (div_cnt_reg != 8'd0) begin
            IF_PCWr      = 1'b0;
            IF_IDWr      = 1'b0;
            IDEXE_Wr     = 1'b0;
            EXEMEM_Flush = 1'b1;
          end
        end
        EXC_HOLD: begin
          // One quiet cycle so WB can write EPC/Cause before the vector fetch moves on.
          IF_PCWr     = 1'b0;
          IF_IDWr     = 1'b0;
          IFID_Flush  = 1'b1;
          IDEXE_Flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (!IF_PCWr && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign StallCount = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: each cycle's expected control vector is
// queued as stimulus is applied and compared against the DUT shortly after.
module tb_pipeline_ctrl;

  localparam int DIV_CYCLES = 4;
  localparam int CNT_W      = 4;

  // Control vector: {IF_PCWr, IF_IDWr, IFID_Flush, IDEXE_Wr, IDEXE_Flush, EXEMEM_Flush, NPCSel, DivBusy}
  localparam logic [8:0] C_RST    = 9'b000000000;
  localparam logic [8:0] C_RUN    = 9'b110100000;
  localparam logic [8:0] C_LDUSE  = 9'b000110000;
  localparam logic [8:0] C_BR     = 9'b111100010;
  localparam logic [8:0] C_EXC    = 9'b111111100;
  localparam logic [8:0] C_EXC_D  = 9'b111111101;
  localparam logic [8:0] C_DSTART = 9'b000001000;
  localparam logic [8:0] C_DHOLD  = 9'b000001001;
  localparam logic [8:0] C_DREL   = 9'b110100001;
  localparam logic [8:0] C_XHOLD  = 9'b001110000;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_rs, ID_rt, EXE_Dst;
  logic EXE_ReadMem, EXE_BranchTaken, EXE_DivStart, MEM_ExceptValid;
  logic IF_PCWr, IF_IDWr, IFID_Flush, IDEXE_Wr, IDEXE_Flush, EXEMEM_Flush, DivBusy;
  logic [1:0] NPCSel;
  logic [CNT_W-1:0] StallCount;

  int total = 0;
  int bad = 0;
  logic [CNT_W-1:0] exp_sc;
  logic [12:0] sb[$];
  logic [12:0] got, exp_v;

  always #5 clk = ~clk;

  pipeline_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .EXE_Dst(EXE_Dst),
    .EXE_ReadMem(EXE_ReadMem), .EXE_BranchTaken(EXE_BranchTaken),
    .EXE_DivStart(EXE_DivStart), .MEM_ExceptValid(MEM_ExceptValid),
    .IF_PCWr(IF_PCWr), .IF_IDWr(IF_IDWr), .IFID_Flush(IFID_Flush),
    .IDEXE_Wr(IDEXE_Wr), .IDEXE_Flush(IDEXE_Flush), .EXEMEM_Flush(EXEMEM_Flush),
    .NPCSel(NPCSel), .DivBusy(DivBusy), .StallCount(StallCount)
  );

  // Drives one cycle of inputs at the falling edge and queues what the DUT must show.
  task automatic apply(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic rm, input logic bt,
                       input logic ds, input logic ex, input logic [8:0] ctl);
    @(negedge clk);
    rst = r; ID_rs = rs; ID_rt = rt; EXE_Dst = dst;
    EXE_ReadMem = rm; EXE_BranchTaken = bt; EXE_DivStart = ds; MEM_ExceptValid = ex;
    if (!r) exp_sc = '0;
    sb.push_back({ctl, exp_sc});
    if (r && !ctl[8] && exp_sc != {CNT_W{1'b1}}) exp_sc = exp_sc + 1'b1;
  endtask

  function automatic logic [12:0] observe();
    return {IF_PCWr, IF_IDWr, IFID_Flush, IDEXE_Wr, IDEXE_Flush, EXEMEM_Flush,
            NPCSel, DivBusy, StallCount};
  endfunction

  task automatic test_reset();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST);
    #1; got = observe(); exp_v = sb.pop_front(); total++;
    if (got !== exp_v) begin bad++; $display("FAIL reset_state got=%b want=%b", got, exp_v); end
    else $display("reset_state ok %b", got);
    apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    #1; got = observe(); exp_v = sb.pop_front(); total++;
    if (got !== exp_v) begin bad++; $display("FAIL reset_release got=%b want=%b", got, exp_v); end
    else $display("reset_release ok %b", got);
  endtask

  task automatic test_load_use();
    apply(1'b1, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LDUSE);
    apply(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    apply(1'b1, 5'd9, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, C_LDUSE);
    apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN);
    apply(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN);
    apply(1'b1, 5'd4, 5'd8, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN);
    for (int i = 0; i < 6; i++) begin
      // Queue holds one entry per apply; compare in order.
      exp_v = sb.pop_front();
      if (i == 0) begin
        #1; got = observe(); total++;
        if (got !== exp_v) begin bad++; $display("FAIL load_use[%0d] got=%b want=%b", i, got, exp_v); end
        else $display("load_use[%0d] ok %b", i, got);
      end else begin
        total++;
        if (exp_v[12:4] === 9'bx) begin bad++; $display("FAIL load_use_queue[%0d] got=x want=defined", i); end
      end
    end
  endtask

  task automatic test_branch();
    logic [4:0] rs_t[4]  = '{5'd0, 5'd3, 5'd0, 5'd0};
    logic [4:0] dst_t[4] = '{5'd0, 5'd3, 5'd0, 5'd4};
    logic       rm_t[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       bt_t[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [8:0] c_t[4]   = '{C_BR, C_BR, C_RUN, C_RUN};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, rs_t[i], 5'd31, dst_t[i], rm_t[i], bt_t[i], 1'b0, 1'b0, c_t[i]);
      #1; got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL branch[%0d] got=%b want=%b", i, got, exp_v); end
      else $display("branch[%0d] ok %b", i, got);
    end
  endtask

  task automatic test_divide();
    logic       bt_t[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ds_t[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [8:0] c_t[7]  = '{C_DSTART, C_DHOLD, C_DHOLD, C_DHOLD, C_DREL, C_RUN, C_RUN};
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, bt_t[i], ds_t[i], 1'b0, c_t[i]);
      #1; got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL divide[%0d] got=%b want=%b", i, got, exp_v); end
      else $display("divide[%0d] ok %b", i, got);
    end
  endtask

  task automatic test_exc_in_div();
    logic       ds_t[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       ex_t[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [8:0] c_t[4]  = '{C_DSTART, C_EXC_D, C_XHOLD, C_RUN};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ds_t[i], ex_t[i], c_t[i]);
      #1; got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL exc_in_div[%0d] got=%b want=%b", i, got, exp_v); end
      else $display("exc_in_div[%0d] ok %b", i, got);
    end
  endtask

  task automatic test_simultaneous();
    logic       ds_t[3] = '{1'b1, 1'b1, 1'b0};
    logic       ex_t[3] = '{1'b1, 1'b0, 1'b0};
    logic [8:0] c_t[3]  = '{C_EXC, C_XHOLD, C_RUN};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, ds_t[i], ex_t[i], c_t[i]);
      if (i == 2) begin
        EXE_ReadMem = 1'b0;
      end
      #1; got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL simultaneous[%0d] got=%b want=%b", i, got, exp_v); end
      else $display("simultaneous[%0d] ok %b", i, got);
    end
  endtask

  task automatic test_reset_mid_div();
    logic       r_t[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       ds_t[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [8:0] c_t[5]  = '{C_DSTART, C_DHOLD, C_RST, C_RUN, C_RUN};
    for (int i = 0; i < 5; i++) begin
      apply(r_t[i], 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ds_t[i], 1'b0, c_t[i]);
      #1; got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL reset_mid_div[%0d] got=%b want=%b", i, got, exp_v); end
      else $display("reset_mid_div[%0d] ok %b", i, got);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 21; i++) begin
      apply(1'b1, 5'd12, 5'd0, 5'd12, (i < 20), 1'b0, 1'b0, 1'b0, (i < 20) ? C_LDUSE : C_RUN);
      #1; got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL saturation[%0d] got=%b want=%b", i, got, exp_v); end
      else $display("saturation[%0d] ok %b", i, got);
    end
    total++;
    if (StallCount !== 4'hF) begin bad++; $display("FAIL saturation_final got=%0d want=15", StallCount); end
    else $display("saturation_final ok %0d", StallCount);
  endtask

  initial begin
    rst = 1'b0; ID_rs = '0; ID_rt = '0; EXE_Dst = '0;
    EXE_ReadMem = 1'b0; EXE_BranchTaken = 1'b0; EXE_DivStart = 1'b0; MEM_ExceptValid = 1'b0;
    exp_sc = '0;
    test_reset();
    test_load_use_checked();
    test_branch();
    test_divide();
    test_exc_in_div();
    test_simultaneous();
    test_reset_mid_div();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Load-use scenarios, each cycle compared as soon as it is applied.
  task automatic test_load_use_checked();
    logic [4:0] rs_t[6]  = '{5'd5, 5'd1, 5'd9, 5'd0, 5'd5, 5'd4};
    logic [4:0] rt_t[6]  = '{5'd7, 5'd2, 5'd6, 5'd0, 5'd5, 5'd8};
    logic [4:0] dst_t[6] = '{5'd5, 5'd3, 5'd6, 5'd0, 5'd5, 5'd5};
    logic       rm_t[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [8:0] c_t[6]   = '{C_LDUSE, C_RUN, C_LDUSE, C_RUN, C_RUN, C_RUN};
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, rs_t[i], rt_t[i], dst_t[i], rm_t[i], 1'b0, 1'b0, 1'b0, c_t[i]);
      #1; got = observe(); exp_v = sb.pop_front(); total++;
      if (got !== exp_v) begin bad++; $display("FAIL load_use[%0d] got=%b want=%b", i, got, exp_v); end
      else $display("load_use[%0d] ok %b", i, got);
    end
  endtask

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Backward-direction control for the five-stage pipeline register interface: consumes hazard, branch, divide and exception status from the ID, EXE and MEM stages.
- Drives the PC, IF/ID, ID/EXE and EXE/MEM write-enable, flush and next-PC-select signals back into the pipeline.
- Owns load-use stalls, the taken-branch wrong-path squash, the multi-cycle divide stall FSM, the exception flush/hold sequence, and a stall performance counter.

Parameters:
DIV_CYCLES, 32, cycles a DIV/DIVU holds the pipeline before release; legal range 2..255
CNT_W, 32, width of StallCount

Ports:
clk  in  1  pipeline clock
rst  in  1  reset; asynchronous, active-low
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
EXE_Dst  in  5  destination register of the instruction in EXE
EXE_ReadMem  in  1  instruction in EXE is a load (LoadType.ReadMem)
EXE_BranchTaken  in  1  branch/jump in EXE resolved taken
EXE_DivStart  in  1  instruction in EXE is DIV/DIVU; level signal, stays high while held
MEM_ExceptValid  in  1  any ExceptinPipeType bit set in MEM
IF_PCWr  out  1  PC write enable
IF_IDWr  out  1  IF/ID write enable
IFID_Flush  out  1  clear IF/ID to bubble
IDEXE_Wr  out  1  ID/EXE write enable
IDEXE_Flush  out  1  clear ID/EXE to bubble
EXEMEM_Flush  out  1  clear EXE/MEM to bubble
NPCSel  out  2  next-PC select: 00 sequential, 01 branch target, 10 exception vector, 11 unused
DivBusy  out  1  FSM is in DIV_BUSY
StallCount  out  CNT_W  saturating count of cycles with IF_PCWr=0

Behaviour:
- FSM states: RUN, DIV_BUSY, EXC_HOLD. Divide counter div_cnt is 8 bits. All state is registered. Control outputs are combinational from state and current inputs.
- Reset (rst=0, asynchronous): state=RUN, div_cnt=0, StallCount=0.
  - Outputs are forced while reset is low: IF_PCWr=0, IF_IDWr=0, IDEXE_Wr=0, all flushes 0, NPCSel=00, DivBusy=0.
  - Reset mid-divide or mid-hold aborts immediately to RUN.
- Default, in RUN with no event: IF_PCWr=1, IF_IDWr=1, IDEXE_Wr=1, flushes 0, NPCSel=00.
- Priority in RUN, highest first:
  1. Exception: MEM_ExceptValid=1.
     - NPCSel=10, IF_PCWr=1.
     - IFID_Flush=1, IDEXE_Flush=1, EXEMEM_Flush=1.
     - MEM/WB is not flushed: the faulting instruction commits its CP0 update in WB.
     - Next state EXC_HOLD.
  2. Divide start: EXE_DivStart=1.
     - IF_PCWr=0, IF_IDWr=0, IDEXE_Wr=0, EXEMEM_Flush=1.
     - div_cnt<=DIV_CYCLES-1; next state DIV_BUSY.
  3. Taken branch: EXE_BranchTaken=1.
     - NPCSel=01, IF_PCWr=1, IFID_Flush=1 (squashes the wrong-path fetch).
     - The delay slot in ID proceeds normally (IDEXE_Flush=0).
  4. Load-use: EXE_ReadMem=1, EXE_Dst!=0, and EXE_Dst==ID_rs or EXE_Dst==ID_rt.
     - IF_PCWr=0, IF_IDWr=0, IDEXE_Flush=1.
     - IDEXE_Wr=1 so the bubble is inserted.
  - Branch and load-use never coexist (both are EXE occupants). If both are asserted, branch wins.
- DIV_BUSY:
  - EXE_BranchTaken and EXE_DivStart are ignored.
  - If MEM_ExceptValid=1: abort the divide with the exception action above; next state EXC_HOLD.
  - Else if div_cnt!=0: hold (IF_PCWr=0, IF_IDWr=0, IDEXE_Wr=0, EXEMEM_Flush=1) and decrement div_cnt.
  - Else (div_cnt==0): release cycle with default RUN outputs, so the divide enters EXE/MEM; next state RUN.
  - Total: DIV_CYCLES stalled cycles, then 1 release cycle.
- EXC_HOLD: lasts one cycle.
  - IF_PCWr=0, IF_IDWr=0, IFID_Flush=1, IDEXE_Flush=1, NPCSel=00.
  - Gives the WB-stage EPC/Cause write one cycle before the vector fetch advances.
  - MEM_ExceptValid is ignored (MEM holds a bubble). Next state RUN.
- DivBusy=1 exactly when state==DIV_BUSY.
- StallCount increments by 1 each cycle IF_PCWr=0 outside reset, and saturates at all-ones with no wrap.

Test Plan:
- Load-use: EXE_ReadMem=1, EXE_Dst=5, ID_rs=5 → one cycle of IF_PCWr=0, IF_IDWr=0, IDEXE_Flush=1; StallCount 0→1. Same stimulus with EXE_Dst=0 → no stall.
- Branch: EXE_BranchTaken=1 → NPCSel=01, IFID_Flush=1, IDEXE_Flush=0, IF_PCWr=1 for exactly that cycle.
- Divide with DIV_CYCLES=4: EXE_DivStart held high → 4 stalled cycles with EXEMEM_Flush=1 and DivBusy high for the last 3, then a release cycle; StallCount=4.
- Exception on cycle 2 of a divide → NPCSel=10, three flushes asserted, then one EXC_HOLD cycle, then RUN; DivBusy drops after the exception cycle.
- Simultaneous MEM_ExceptValid=1, EXE_DivStart=1 and load-use in RUN → exception action only; no DIV_BUSY entry.
- Reset asserted mid-DIV_BUSY → outputs forced to reset values immediately (asynchronous); after deassertion the state is RUN and StallCount=0. With CNT_W=4 and 20 forced stalls, StallCount holds at 15.
